serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor built on the half-subtractor / full-subtractor cell. It computes A − B − borrow_in over WIDTH/CHUNK clock cycles, processing CHUNK bits per cycle, LSB chunk first, with a ripple borrow held in a register between cycles. It sits beside the combinational arithmetic blocks as the area-lean datapath option. A start/busy/done handshake gives it a fixed, parameter-determined latency.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - borrow_in over WIDTH/CHUNK cycles, LSB chunk first,
// with the inter-chunk borrow held in a register.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf,
    output logic [0:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Handshake: an operation is accepted on any edge where start is high and busy is low;
    // start is ignored (not queued) while busy. done pulses for one cycle when the result
    // registers update, and that cycle is already idle, so start there is accepted.

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] result;
    logic             last;
    logic             accept;

    assign accept    = (state == IDLE) && start;
    assign last      = (cnt == CW'(NCHUNK - 1));
    assign chunk_res = {1'b0, wa[CHUNK-1:0]} - {1'b0, wb[CHUNK-1:0]} - {{CHUNK{1'b0}}, brw};
    assign busy      = (state == RUN);
    assign state_dbg = state;

    // Only the upper WIDTH-CHUNK bits of the partial difference need storage: the
    // newest chunk enters at the top and the final chunk goes straight to diff.
    if (NCHUNK > 1) begin : g_acc
        logic [WIDTH-CHUNK-1:0] acc;

        assign result = {chunk_res[CHUNK-1:0], acc};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (accept) begin
                acc <= '0;
            end else if (state == RUN) begin
                acc <= result[WIDTH-1:CHUNK];
            end
        end
    end else begin : g_single
        assign result = chunk_res[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wa         <= '0;
            wb         <= '0;
            brw        <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        wa    <= a;
                        wb    <= b;
                        brw   <= borrow_in;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    wa   <= wa >> CHUNK;
                    wb   <= wb >> CHUNK;
                    brw  <= chunk_res[CHUNK];
                    cnt  <= cnt + CW'(1);
                    done <= last;
                    if (last) begin
                        diff       <= result;
                        borrow_out <= chunk_res[CHUNK];
                        zero       <= (result == '0);
                        ovf        <= (a_msb != b_msb) && (result[WIDTH-1] != a_msb);
                        cnt        <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: five instances (8-bit CHUNK 1/4, 4-bit CHUNK 1/2/4) checked
// every cycle against a cycle-level reference model built from plain integer arithmetic.
module tb_serial_subtractor;

    localparam int NINST = 5;
    localparam int NCH [NINST] = '{8, 2, 4, 2, 1};

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus: one input group per operand width
    logic       start8 = 1'b0;
    logic [7:0] a8     = '0;
    logic [7:0] b8     = '0;
    logic       bi8    = 1'b0;
    logic       start4 = 1'b0;
    logic [3:0] a4     = '0;
    logic [3:0] b4     = '0;
    logic       bi4    = 1'b0;

    logic        busy_v [NINST];
    logic        done_v [NINST];
    logic        bo_v   [NINST];
    logic        zero_v [NINST];
    logic        ovf_v  [NINST];
    logic [0:0]  st_v   [NINST];
    logic [7:0]  diff8  [2];
    logic [3:0]  diff4  [3];
    logic [10:0] obs    [NINST];

    for (genvar g = 0; g < 2; g++) begin : g_w8
        serial_subtractor #(.WIDTH(8), .CHUNK(g == 0 ? 1 : 4)) dut (
            .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
            .busy(busy_v[g]), .done(done_v[g]), .diff(diff8[g]), .borrow_out(bo_v[g]),
            .zero(zero_v[g]), .ovf(ovf_v[g]), .state_dbg(st_v[g])
        );
        assign obs[g] = {ovf_v[g], zero_v[g], bo_v[g], diff8[g]};
    end

    for (genvar g = 0; g < 3; g++) begin : g_w4
        serial_subtractor #(.WIDTH(4), .CHUNK(1 << g)) dut (
            .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .borrow_in(bi4),
            .busy(busy_v[g+2]), .done(done_v[g+2]), .diff(diff4[g]), .borrow_out(bo_v[g+2]),
            .zero(zero_v[g+2]), .ovf(ovf_v[g+2]), .state_dbg(st_v[g+2])
        );
        assign obs[g+2] = {ovf_v[g+2], zero_v[g+2], bo_v[g+2], 4'b0000, diff4[g]};
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          free_at [NINST];
    logic [10:0] held    [NINST];
    logic [42:0] exp_q   [NINST][$];   // {done cycle, ovf, zero, borrow, diff}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference arithmetic: {ovf, zero, borrow_out, diff} for a w-bit subtraction.
    function automatic logic [10:0] ref_sub(input int w, input logic [7:0] x,
                                            input logic [7:0] y, input logic bi);
        int         full;
        logic [7:0] d;
        logic       bo;
        logic       z;
        logic       o;
        full = int'(x) - int'(y) - int'(bi);
        d    = 8'(full & ((1 << w) - 1));
        bo   = (full < 0);
        z    = (d == 8'h00);
        o    = (x[w-1] != y[w-1]) && (d[w-1] != x[w-1]);
        return {o, z, bo, d};
    endfunction

    // model: accept on an edge when idle, result due NCH edges later
    initial begin
        for (int k = 0; k < NINST; k++) begin
            free_at[k] = 0;
            held[k]    = '0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                for (int k = 0; k < NINST; k++) begin
                    logic        s;
                    logic [10:0] res;
                    s = (k < 2) ? start8 : start4;
                    if (s && cyc > free_at[k]) begin
                        res = (k < 2) ? ref_sub(8, a8, b8, bi8)
                                      : ref_sub(4, {4'b0000, a4}, {4'b0000, b4}, bi4);
                        free_at[k] = cyc + NCH[k];
                        exp_q[k].push_back({32'(free_at[k]), res});
                    end
                end
            end
        end
    end

    // reset kills in-flight operations and clears the results
    initial forever begin
        @(negedge rst_n);
        for (int k = 0; k < NINST; k++) begin
            exp_q[k].delete();
            free_at[k] = cyc;
            held[k]    = '0;
        end
    end

    // monitor: compare every instance every cycle on the falling edge
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            logic [42:0] ent;
            logic        exp_done;
            logic        exp_busy;
            exp_done = 1'b0;
            ent      = '0;
            if (exp_q[k].size() > 0) begin
                ent = exp_q[k][0];
                if (int'(ent[42:11]) == cyc) exp_done = 1'b1;
            end
            if (exp_done) begin
                held[k] = ent[10:0];
                void'(exp_q[k].pop_front());
            end
            exp_busy = rst_n && (cyc < free_at[k]);
            check($sformatf("done_k%0d_c%0d", k, cyc), 32'(done_v[k]), 32'(exp_done));
            check($sformatf("busy_k%0d_c%0d", k, cyc), 32'(busy_v[k]), 32'(exp_busy));
            check($sformatf("state_k%0d_c%0d", k, cyc), 32'(st_v[k]), 32'(exp_busy));
            check($sformatf("result_k%0d_c%0d", k, cyc), 32'(obs[k]), 32'(held[k]));
        end
    end

    // drivers
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        @(negedge clk);
        a8     = x;
        b8     = y;
        bi8    = bi;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic bi);
        @(negedge clk);
        a4     = x;
        b4     = y;
        bi4    = bi;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bit empty;
            @(negedge clk);
            #1;
            empty = 1'b1;
            for (int k = 0; k < NINST; k++)
                if (exp_q[k].size() != 0) empty = 1'b0;
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_result_k0", 32'(obs[0]), 32'h000);
        check("reset_busy_k0", 32'(busy_v[0]), 32'(0));
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0);
        wait_idle(40);
        check("sub_05_03_k0", 32'(obs[0]), 32'h002);
        check("sub_05_03_k1", 32'(obs[1]), 32'h002);

        op8(8'h03, 8'h05, 1'b0);
        wait_idle(40);
        check("sub_03_05_k0", 32'(obs[0]), 32'h1FE);

        op8(8'h80, 8'h01, 1'b0);
        wait_idle(40);
        check("sub_80_01_ovf_k0", 32'(obs[0]), 32'h47F);

        op8(8'h10, 8'h0F, 1'b1);
        wait_idle(40);
        check("sub_10_0f_bi_k1", 32'(obs[1]), 32'h200);
        check("sub_10_0f_bi_k0", 32'(obs[0]), 32'h200);

        // start while busy: k0 keeps its operation, k1 is idle again and takes the new one
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; bi8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(40);
        check("busy_ignore_k0", 32'(obs[0]), 32'h002);
        check("busy_accept_k1", 32'(obs[1]), 32'h0FF);

        // start held high: back-to-back operations
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h10; start8 = 1'b1;
        repeat (20) @(negedge clk);
        start8 = 1'b0;
        wait_idle(40);
        check("b2b_k0", 32'(obs[0]), 32'h010);

        // asynchronous reset in the 4th RUN cycle
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_result_k0", 32'(obs[0]), 32'h000);
        check("midrun_rst_busy_k0", 32'(busy_v[0]), 32'(0));
        check("midrun_rst_done_k0", 32'(done_v[0]), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(8'h00, 8'h01, 1'b0);
        wait_idle(40);
        check("post_rst_00_01_k0", 32'(obs[0]), 32'h1FF);

        // randomized traffic on both groups, including start while busy
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) != 0);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            bi8    = 1'($urandom_range(0, 1));
            start4 = ($urandom_range(0, 2) != 0);
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            bi4    = 1'($urandom_range(0, 1));
        end
        start8 = 1'b0;
        start4 = 1'b0;
        wait_idle(40);

        // exhaustive 4-bit sweep across CHUNK = 1, 2, 4
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int bi = 0; bi < 2; bi++) begin
                    op4(4'(x), 4'(y), 1'(bi));
                    wait_idle(20);
                end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
